// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control unit: fetch/decode/execute sequencer with memory handshake.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to trap on undefined opcodes
// (sticky illegal_op_o until reset); by default an undefined opcode acts as a NOP.
// Strobes are registered from the next state, except ir_write_o and the fetch part
// of pc_write_o, which complete in the same cycle the memory handshake arrives.
module multicycle_ctrl #(
  parameter int unsigned     OP_W   = 5,
  parameter logic [OP_W-1:0] BNE_OP = OP_W'(5'b01110)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op_i,
  input  logic            mem_ready_i,
  output logic            pc_write_o,
  output logic            pc_write_eq_o,
  output logic            pc_write_ne_o,
  output logic            ir_write_o,
  output logic            i_or_d_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_dst_o,
  output logic            reg_write_o,
  output logic            ext_op_o,
  output logic            alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic [1:0]      alu_op_o,
  output logic [1:0]      pc_src_o,
  output logic [3:0]      state_o,
  output logic            illegal_op_o
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(5'b11000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(5'b00111);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_eff;
  logic            is_r, is_addi, is_slti, is_ori, is_lw, is_sw, is_beq, is_bne, is_j;
  logic            fetch_done_c;
  logic            pc_write_q, pc_write_eq_q, pc_write_ne_q, i_or_d_q, mem_read_q;
  logic            mem_write_q, mem_to_reg_q, reg_dst_q, reg_write_q, ext_op_q, alu_src_a_q;
  logic [1:0]      alu_src_b_q, alu_op_q, pc_src_q;

  // Opcode decode: live opcode while in DECODE, latched copy afterwards
  always_comb begin
    op_eff  = (state_q == S_DECODE) ? op_i : op_q;
    is_r    = (op_eff == OP_RTYPE);
    is_addi = (op_eff == OP_ADDI);
    is_slti = (op_eff == OP_SLTI);
    is_ori  = (op_eff == OP_ORI);
    is_lw   = (op_eff == OP_LW);
    is_sw   = (op_eff == OP_SW);
    is_beq  = (op_eff == OP_BEQ);
    is_bne  = (op_eff == BNE_OP) && !is_beq;
    is_j    = (op_eff == OP_J);
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        if (is_r)                           state_d = S_EXEC;
        else if (is_addi || is_slti || is_ori) state_d = S_IMMEX;
        else if (is_lw || is_sw)            state_d = S_MEMADR;
        else if (is_beq || is_bne)          state_d = S_BRANCH;
        else if (is_j)                      state_d = S_JUMP;
        else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR: state_d = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready_i) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`else
      S_TRAP:   state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // State, opcode latch and registered strobes decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      pc_write_q    <= 1'b0;
      pc_write_eq_q <= 1'b0;
      pc_write_ne_q <= 1'b0;
      i_or_d_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_dst_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      ext_op_q      <= 1'b0;
      alu_src_a_q   <= 1'b0;
      alu_src_b_q   <= 2'b00;
      alu_op_q      <= 2'b00;
      pc_src_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      if (state_q == S_DECODE) op_q <= op_i;
      pc_write_q    <= 1'b0;
      pc_write_eq_q <= 1'b0;
      pc_write_ne_q <= 1'b0;
      i_or_d_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      reg_dst_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      ext_op_q      <= 1'b0;
      alu_src_a_q   <= 1'b0;
      alu_src_b_q   <= 2'b00;
      alu_op_q      <= 2'b00;
      pc_src_q      <= 2'b00;
      unique case (state_d)
        S_FETCH:  begin mem_read_q <= 1'b1; alu_src_b_q <= 2'b01; end
        S_DECODE: begin alu_src_b_q <= 2'b10; ext_op_q <= 1'b1; end
        S_MEMADR: begin alu_src_a_q <= 1'b1; alu_src_b_q <= 2'b10; ext_op_q <= 1'b1; end
        S_MEMRD:  begin mem_read_q <= 1'b1; i_or_d_q <= 1'b1; end
        S_MEMWB:  begin reg_write_q <= 1'b1; mem_to_reg_q <= 1'b1; end
        S_MEMWR:  begin mem_write_q <= 1'b1; i_or_d_q <= 1'b1; end
        S_EXEC:   begin alu_src_a_q <= 1'b1; alu_op_q <= 2'b10; end
        S_ALUWB:  begin reg_write_q <= 1'b1; reg_dst_q <= 1'b1; end
        S_IMMEX:  begin
          alu_src_a_q <= 1'b1;
          alu_src_b_q <= 2'b10;
          ext_op_q    <= !is_ori;
          alu_op_q    <= is_ori ? 2'b11 : (is_slti ? 2'b01 : 2'b00);
        end
        S_IMMWB:  reg_write_q <= 1'b1;
        S_BRANCH: begin
          alu_src_a_q   <= 1'b1;
          alu_op_q      <= 2'b01;
          pc_src_q      <= 2'b01;
          pc_write_eq_q <= is_beq;
          pc_write_ne_q <= is_bne;
        end
        S_JUMP:   begin pc_src_q <= 2'b10; pc_write_q <= 1'b1; end
        default:  ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic illegal_q;

  // Sticky undefined-opcode flag, held for as long as the FSM sits in TRAP
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= (state_d == S_TRAP);
  end

  assign illegal_op_o = illegal_q;
`else
  assign illegal_op_o = 1'b0;
`endif

  assign fetch_done_c  = (state_q == S_FETCH) && mem_ready_i;
  assign ir_write_o    = fetch_done_c;
  assign pc_write_o    = pc_write_q | fetch_done_c;
  assign pc_write_eq_o = pc_write_eq_q;
  assign pc_write_ne_o = pc_write_ne_q;
  assign i_or_d_o      = i_or_d_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_to_reg_o  = mem_to_reg_q;
  assign reg_dst_o     = reg_dst_q;
  assign reg_write_o   = reg_write_q;
  assign ext_op_o      = ext_op_q;
  assign alu_src_a_o   = alu_src_a_q;
  assign alu_src_b_o   = alu_src_b_q;
  assign alu_op_o      = alu_op_q;
  assign pc_src_o      = pc_src_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a per-instruction reference model pushes the
// expected per-cycle observation, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_SLTI = 5'b10010;
  localparam logic [4:0] OP_ORI  = 5'b11000;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b01111;
  localparam logic [4:0] OP_BNE  = 5'b01110;
  localparam logic [4:0] OP_J    = 5'b00111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcweq, pcwne, irw, iord, mrd, mwr, m2r, rdst, rw, ext, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, ext_op, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_eq_o(pc_write_eq), .pc_write_ne_o(pc_write_ne),
    .ir_write_o(ir_write), .i_or_d_o(i_or_d), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
    .reg_write_o(reg_write), .ext_op_o(ext_op), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
    .state_o(state), .illegal_op_o(illegal_op)
  );

  // Monitor: every cycle with a pending expectation is compared away from the edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{st: state, pcw: pc_write, pcweq: pc_write_eq, pcwne: pc_write_ne,
                irw: ir_write, iord: i_or_d, mrd: mem_read, mwr: mem_write,
                m2r: mem_to_reg, rdst: reg_dst, rw: reg_write, ext: ext_op,
                srca: alu_src_a, srcb: alu_src_b, aluop: alu_op, pcsrc: pc_src,
                ill: illegal_op};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL cycle_obs t=%0t exp_state=%0d act=%h exp=%h", $time, mon_e.st, mon_a, mon_e);
      end
      if (mem_read && mem_write) begin
        checks++;
        errors++;
        $display("FAIL rd_wr_exclusive t=%0t act=11 required=not both", $time);
      end
    end
  end

  function automatic obs_t ob(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [4:0] rnd5();
    return 5'($urandom);
  endfunction

  // Instruction class from the opcode table: 0 R,1 imm,2 lw,3 sw,4 branch,5 jump,6 undefined
  function automatic int cls(input logic [4:0] o);
    if (o == OP_R) return 0;
    if (o == OP_ADDI || o == OP_SLTI || o == OP_ORI) return 1;
    if (o == OP_LW) return 2;
    if (o == OP_SW) return 3;
    if (o == OP_BEQ || o == OP_BNE) return 4;
    if (o == OP_J) return 5;
    return 6;
  endfunction

  // Drive one cycle's inputs and record what the outputs must be during it
  task automatic cyc(input logic [4:0] o, input logic rdy, input logic rs, input obs_t e);
    @(posedge clk);
    #1;
    op = o;
    mem_ready = rdy;
    rst_n = rs;
    exp_q.push_back(e);
  endtask

  task automatic fetch_decode(input logic [4:0] o, input int fw);
    obs_t e;
    e = ob(4'd1); e.mrd = 1'b1; e.srcb = 2'b01;
    for (int i = 0; i < fw; i++) cyc(rnd5(), 1'b0, 1'b1, e);
    e.irw = 1'b1; e.pcw = 1'b1;
    cyc(rnd5(), 1'b1, 1'b1, e);
    e = ob(4'd2); e.srcb = 2'b10; e.ext = 1'b1;
    cyc(o, 1'($urandom), 1'b1, e);
  endtask

  // Reference model for one whole instruction, starting at FETCH
  task automatic run_instr(input logic [4:0] o, input int fw, input int mw);
    obs_t e;
    fetch_decode(o, fw);
    case (cls(o))
      0: begin
        e = ob(4'd7); e.srca = 1'b1; e.aluop = 2'b10;
        cyc(rnd5(), 1'($urandom), 1'b1, e);
        e = ob(4'd8); e.rw = 1'b1; e.rdst = 1'b1;
        cyc(rnd5(), 1'($urandom), 1'b1, e);
      end
      1: begin
        e = ob(4'd9); e.srca = 1'b1; e.srcb = 2'b10;
        if (o == OP_ORI) begin e.ext = 1'b0; e.aluop = 2'b11; end
        else begin e.ext = 1'b1; e.aluop = (o == OP_SLTI) ? 2'b01 : 2'b00; end
        cyc(rnd5(), 1'($urandom), 1'b1, e);
        e = ob(4'd10); e.rw = 1'b1;
        cyc(rnd5(), 1'($urandom), 1'b1, e);
      end
      2, 3: begin
        e = ob(4'd3); e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
        cyc(rnd5(), 1'($urandom), 1'b1, e);
        if (o == OP_LW) begin e = ob(4'd4); e.mrd = 1'b1; end
        else begin e = ob(4'd6); e.mwr = 1'b1; end
        e.iord = 1'b1;
        for (int i = 0; i < mw; i++) cyc(rnd5(), 1'b0, 1'b1, e);
        cyc(rnd5(), 1'b1, 1'b1, e);
        if (o == OP_LW) begin
          e = ob(4'd5); e.rw = 1'b1; e.m2r = 1'b1;
          cyc(rnd5(), 1'($urandom), 1'b1, e);
        end
      end
      4: begin
        e = ob(4'd11); e.srca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
        e.pcweq = (o == OP_BEQ); e.pcwne = (o == OP_BNE);
        cyc(rnd5(), 1'($urandom), 1'b1, e);
      end
      5: begin
        e = ob(4'd12); e.pcsrc = 2'b10; e.pcw = 1'b1;
        cyc(rnd5(), 1'($urandom), 1'b1, e);
      end
      default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        e = ob(4'd13); e.ill = 1'b1;
        for (int i = 0; i < 3; i++) cyc(rnd5(), 1'($urandom), 1'b1, e);
        cyc(rnd5(), 1'($urandom), 1'b0, e);
        cyc(rnd5(), 1'($urandom), 1'b1, ob(4'd0));
`endif
      end
    endcase
  endtask

  // Store stalled on memory, then reset lands while mem_write is asserted
  task automatic sw_abort();
    obs_t e;
    fetch_decode(OP_SW, 0);
    e = ob(4'd3); e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
    cyc(rnd5(), 1'b0, 1'b1, e);
    e = ob(4'd6); e.mwr = 1'b1; e.iord = 1'b1;
    cyc(rnd5(), 1'b0, 1'b1, e);
    cyc(rnd5(), 1'b0, 1'b1, e);
    cyc(rnd5(), 1'b0, 1'b0, e);
    cyc(rnd5(), 1'b0, 1'b1, ob(4'd0));
  endtask

  logic [4:0] legal [9];
  logic [4:0] pick;

  initial begin
    legal = '{OP_R, OP_ADDI, OP_SLTI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    rst_n = 1'b0;
    op = 5'b0;
    mem_ready = 1'b0;
    cyc(rnd5(), 1'b1, 1'b0, ob(4'd0));
    cyc(rnd5(), 1'b1, 1'b1, ob(4'd0));
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 1, 3);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_BNE, 2, 0);
    run_instr(OP_J, 0, 0);
    run_instr(5'b11111, 0, 0);
    run_instr(OP_SW, 0, 2);
    run_instr(OP_ADDI, 0, 0);
    run_instr(OP_SLTI, 1, 0);
    run_instr(OP_ORI, 0, 0);
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) pick = rnd5();
      else pick = legal[$urandom_range(0, 8)];
      run_instr(pick, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    sw_abort();
    run_instr(OP_R, 0, 0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain act=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
